s2mm_stream_arbiter: RTL and testbench
======================================

Name: s2mm_stream_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single DMA S2MM AXI-Stream slave port among NUM_SRC PL stream producers. Once a source is granted, it keeps the grant until its tlast beat completes, so packets never interleave in DDR buffers. Sits between the PL producers (counters, capture blocks) and the S2MM input of the block-design wrapper. Software gates it through a GPIO bit on `enable`.

Parameters:
NUM_SRC, 4, number of requesting stream sources (2..8)
DATA_W, 32, stream data width in bits (multiple of 8)
MAX_BEATS, 128, maximum packet length in beats (512 bytes / 4); used only with the optional feature

Ports:
FCLK_CLK0  in  1  fabric clock from PS
FCLK_RESET0_N  in  1  asynchronous active-low reset
enable  in  1  GPIO gate; 0 = accept no new packets
s_axis_tdata  in  NUM_SRC*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W]
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tlast  in  NUM_SRC  per-source last
s_axis_tready  out  NUM_SRC  per-source ready
m_axis_tdata  out  DATA_W  to S2MM tdata
m_axis_tkeep  out  DATA_W/8  constant all ones
m_axis_tvalid  out  1  to S2MM tvalid
m_axis_tlast  out  1  to S2MM tlast
m_axis_tready  in  1  from S2MM tready
grant_oh  out  NUM_SRC  one-hot current grant, 0 when idle
busy  out  1  packet in progress
pkt_count  out  32  completed packets since reset, wraps at 2^32
overflow  out  1  sticky; see Optional Feature

Behaviour:
- Clock and reset: single clock FCLK_CLK0. Reset FCLK_RESET0_N is asynchronous and active-low.
- Reset values: state IDLE; grant_oh=0; busy=0; pkt_count=0; overflow=0; rr pointer=0; all s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0.
- FSM has two states, IDLE and PKT.
- IDLE:
  - m_axis_tvalid=0 and all tready=0.
  - If enable=1 and any s_axis_tvalid=1, choose the first valid source at or after rr pointer, searching upward with wrap.
  - Register grant_oh and go to PKT on the next edge. Arbitration latency is one cycle from request to grant.
- PKT, datapath (pure combinational mux from the granted source, no register stage):
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast = granted source's signals.
  - s_axis_tready[g] = m_axis_tready; all other tready=0.
- PKT, packet completion:
  - A handshake (m_axis_tvalid & m_axis_tready) with m_axis_tlast=1 ends the packet.
  - On that edge: pkt_count+1; rr pointer = g+1 mod NUM_SRC; grant_oh=0; go to IDLE.
  - Minimum gap between packets is one IDLE cycle.
- enable falling mid-packet: the current packet completes normally, then the block stays in IDLE. `enable` is sampled only in IDLE.
- Granted source drops tvalid mid-packet: the grant is held and output tvalid=0. No timeout.
- Simultaneous requests: strict rotation from the rr pointer, so no source is starved while its tvalid is held.
- Reset mid-packet: immediate return to the reset values. The downstream DMA sees a truncated packet; software must reset the DMA.
- busy = (state==PKT).
- beat counter: width clog2(MAX_BEATS+1). Cleared on grant, incremented on every output handshake. Maintained only with the feature enabled.

Optional Feature:
Macro S2MM_ARB_PKT_LIMIT_EN.
- Defined:
  - On the MAX_BEATS-th handshake of a packet, m_axis_tlast is forced to 1 and the packet ends (pkt_count+1, rotate, IDLE).
  - If the source's own tlast was 0 on that beat, overflow is set and stays set until reset.
  - The source's remaining beats form a new packet in a later grant.
- Undefined: no beat counter is built, overflow is tied to 0, and packets are unbounded.

Decomposition:
- Package s2mm_arb_pkg:
  - FSM state enum (IDLE, PKT).
  - Default widths.
  - Function clog2.
  - Function rr_pick(valid, ptr), returning a one-hot grant.
- One natural sub-module: rr_arbiter (combinational one-hot round-robin pick from a request vector and pointer), reusable elsewhere.
- Top module holds the FSM, mux, counters and feature logic.

Test Plan:
- Single source 0 streams 4 beats with tlast on beat 4 and m_axis_tready=1 -> grant_oh=0001 one cycle after tvalid, 4 output beats in order, pkt_count=1, busy falls after beat 4.
- All 4 sources valid continuously, 2-beat packets -> grant order 0,1,2,3,0. No interleaving between tlast boundaries. pkt_count=5 after 5 packets.
- m_axis_tready toggled 1/0 every cycle during a source 2 packet -> data held stable while stalled. s_axis_tready[2] mirrors m_axis_tready. Other treadys stay 0.
- enable driven 0 on beat 2 of an 8-beat packet -> all 8 beats delivered, then no new grant while other sources' tvalid=1. Re-raising enable resumes arbitration at rr pointer = next source.
- FCLK_RESET0_N pulsed low mid-packet, asynchronous to the clock -> outputs reach reset values without waiting for a clock edge. pkt_count=0.
- With S2MM_ARB_PKT_LIMIT_EN and MAX_BEATS=128, source sends a 130-beat packet -> tlast forced on beat 128, overflow=1, remaining 2 beats emitted as a separate packet, pkt_count=2.

Source files
------------

// File: rtl/s2mm_stream_arbiter_pkg.sv
// Shared types and helpers for the S2MM stream arbiter: FSM states, default
// widths, clog2 and a one-hot round-robin pick.
package s2mm_arb_pkg;

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

    localparam int unsigned DEF_NUM_SRC   = 4;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_BEATS = 128;
    localparam int unsigned RR_MAX_SRC    = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // First set bit of valid at or above ptr, wrapping within n sources.
    function automatic logic [RR_MAX_SRC-1:0] rr_pick(
        input logic [RR_MAX_SRC-1:0] valid,
        input logic [2:0]            ptr,
        input int unsigned           n
    );
        logic [RR_MAX_SRC-1:0] oh;
        logic [3:0]            idx;
        oh = '0;
        for (int unsigned off = 0; off < RR_MAX_SRC; off++) begin
            idx = 4'(ptr) + 4'(off);
            if (idx >= 4'(n)) idx = idx - 4'(n);
            if ((off < n) && (oh == '0) && valid[idx[2:0]]) oh[idx[2:0]] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/s2mm_stream_arbiter_rr_arbiter.sv
// Combinational one-hot round-robin pick from a request vector and pointer.
module rr_arbiter
    import s2mm_arb_pkg::*;
#(
    parameter int unsigned N     = DEF_NUM_SRC,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant_oh_c
);

    logic [RR_MAX_SRC-1:0] pick;
    logic                  unused_pick;

    always_comb pick = rr_pick(RR_MAX_SRC'(req), 3'(ptr), N);

    assign grant_oh_c  = N'(pick);
    assign unused_pick = ^pick;

endmodule

// File: rtl/s2mm_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one S2MM AXI-Stream port.
// Optional S2MM_ARB_PKT_LIMIT_EN caps packets at MAX_BEATS and flags overflow.
module s2mm_stream_arbiter
    import s2mm_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                      FCLK_CLK0,
    input  logic                      FCLK_RESET0_N,
    input  logic                      enable,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [DATA_W/8-1:0]       m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [NUM_SRC-1:0]        grant_oh,
    output logic                      busy,
    output logic [31:0]               pkt_count,
    output logic                      overflow
);

    localparam int unsigned PTR_W = (clog2(NUM_SRC) < 1) ? 1 : clog2(NUM_SRC);

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d, pick_c;
    logic [PTR_W-1:0]   gidx_q, gidx_d, rr_q, rr_d, pick_idx;
    logic [31:0]        cnt_q, cnt_d;
    logic               src_last, hs, pkt_end, limit_c;

    rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr (
        .req        (s_axis_tvalid),
        .ptr        (rr_q),
        .grant_oh_c (pick_c)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++)
            if (pick_c[i]) pick_idx = PTR_W'(i);
    end

    // Unregistered datapath from the granted source; quiet while idle.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        src_last      = 1'b0;
        s_axis_tready = '0;
        if (state_q == PKT) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (gidx_q == PTR_W'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*DATA_W +: DATA_W];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    src_last         = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign m_axis_tlast = src_last | limit_c;
    assign hs           = m_axis_tvalid & m_axis_tready;
    assign pkt_end      = hs & m_axis_tlast;

    always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
        if (!FCLK_RESET0_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && (|s_axis_tvalid)) begin
                    state_d = PKT;
                    grant_d = pick_c;
                    gidx_d  = pick_idx;
                end
            end
            PKT: begin
                if (pkt_end) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = cnt_q + 32'd1;
                    rr_d    = (gidx_q == PTR_W'(NUM_SRC - 1)) ? '0 : gidx_q + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef S2MM_ARB_PKT_LIMIT_EN
    localparam int unsigned BEAT_W = clog2(MAX_BEATS + 1);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              ovf_q, ovf_d;

    // Last allowed beat of a packet forces tlast so DDR buffers never overrun.
    assign limit_c = (state_q == PKT) && (beat_q == BEAT_W'(MAX_BEATS - 1));

    always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
        if (!FCLK_RESET0_N) begin
            beat_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        beat_d = beat_q;
        ovf_d  = ovf_q;
        if (state_q == IDLE) beat_d = '0;
        else if (hs)         beat_d = beat_q + BEAT_W'(1);
        if (hs && limit_c && !src_last) ovf_d = 1'b1;
    end

    assign overflow = ovf_q;
`else
    assign limit_c  = 1'b0;
    assign overflow = 1'b0;
`endif

    assign grant_oh     = grant_q;
    assign busy         = (state_q == PKT);
    assign pkt_count    = cnt_q;
    assign m_axis_tkeep = '1;

endmodule

// File: tb/tb_s2mm_stream_arbiter.sv
// Scoreboard bench for s2mm_stream_arbiter: per-source packet memories drive
// the inputs, expected beats are queued in predicted grant order.
`timescale 1ns/1ps
module tb_s2mm_stream_arbiter;

    localparam int unsigned NUM_SRC   = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BEATS = 128;

    logic                      FCLK_CLK0 = 1'b0;
    logic                      FCLK_RESET0_N;
    logic                      enable;
    logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DATA_W-1:0]         m_axis_tdata;
    logic [DATA_W/8-1:0]       m_axis_tkeep;
    logic                      m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [NUM_SRC-1:0]        grant_oh;
    logic                      busy;
    logic [31:0]               pkt_count;
    logic                      overflow;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [32:0] mem [NUM_SRC][256];
    int          wr [NUM_SRC];
    int          rd [NUM_SRC];
    int          n_tests, n_fail, out_beats, base;
    bit          rdy_toggle, gap_en;

    s2mm_stream_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .FCLK_CLK0     (FCLK_CLK0),
        .FCLK_RESET0_N (FCLK_RESET0_N),
        .enable        (enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_oh      (grant_oh),
        .busy          (busy),
        .pkt_count     (pkt_count),
        .overflow      (overflow)
    );

    initial forever #5 FCLK_CLK0 = ~FCLK_CLK0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] mk_data(input int src, input int pkt, input int beat);
        return {4'hA, 4'(src), 8'(pkt), 16'(beat)};
    endfunction

    task automatic load_pkt(input int src, input int pkt, input int len);
        for (int k = 0; k < len; k++)
            mem[src][wr[src] + k] = {(k == len - 1), mk_data(src, pkt, k)};
        wr[src] += len;
    endtask

    task automatic expect_beats(input int src, input int pkt, input int first, input int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            e.src  = 2'(src);
            e.data = mk_data(src, pkt, first + k);
            e.last = (k == count - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge FCLK_CLK0);
            done = (exp_q.size() == 0) && !busy;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_beats(input string tag, input int target);
        for (int c = 0; c < 1000 && out_beats < target; c++) @(negedge FCLK_CLK0);
        check(tag, out_beats >= target, 1'b1);
    endtask

    task automatic apply_reset();
        FCLK_RESET0_N = 1'b0;
        repeat (2) @(posedge FCLK_CLK0);
        #2;
        for (int i = 0; i < NUM_SRC; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        exp_q.delete();
        @(posedge FCLK_CLK0);
        #2;
        @(negedge FCLK_CLK0);
        FCLK_RESET0_N = 1'b1;
    endtask

    // Source model: advance on handshake, present the next stored beat.
    initial begin : driver
        bit hs [NUM_SRC];
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge FCLK_CLK0);
            for (int i = 0; i < NUM_SRC; i++) hs[i] = s_axis_tvalid[i] && s_axis_tready[i];
            @(posedge FCLK_CLK0);
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (FCLK_RESET0_N && hs[i]) rd[i]++;
                s_axis_tvalid[i] = (rd[i] < wr[i]) && !(gap_en && ($urandom_range(0, 3) == 0));
                {s_axis_tlast[i], s_axis_tdata[i*DATA_W +: DATA_W]} = mem[i][rd[i]];
            end
            m_axis_tready = rdy_toggle ? !m_axis_tready : 1'b1;
        end
    end

    initial begin : monitor
        exp_t               e;
        bit                 prev_stall;
        logic [31:0]        prev_data;
        logic [NUM_SRC-1:0] oh;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge FCLK_CLK0);
            if (!FCLK_RESET0_N) begin
                prev_stall = 1'b0;
                continue;
            end
            if (busy) check("tready_route", s_axis_tready, m_axis_tready ? grant_oh : '0);
            if (prev_stall && m_axis_tvalid) check("stall_hold", m_axis_tdata, prev_data);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                out_beats++;
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e.src] = 1'b1;
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_last", m_axis_tlast, e.last);
                    check("beat_grant", grant_oh, oh);
                end
            end
        end
    end

    initial begin : main
        n_tests = 0; n_fail = 0; out_beats = 0;
        rdy_toggle = 1'b0; gap_en = 1'b0; enable = 1'b1;
        FCLK_RESET0_N = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            wr[i] = 0;
            rd[i] = 0;
            for (int k = 0; k < 256; k++) mem[i][k] = '0;
        end
        apply_reset();

        @(negedge FCLK_CLK0);
        check("rst_grant", grant_oh, 0);
        check("rst_busy", busy, 0);
        check("rst_count", pkt_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tready", s_axis_tready, 0);
        check("tkeep", m_axis_tkeep, 4'hF);

        // Single source, one-cycle arbitration latency.
        load_pkt(0, 1, 4);
        expect_beats(0, 1, 0, 4);
        @(negedge FCLK_CLK0);
        check("t1_pre_grant", grant_oh, 0);
        @(negedge FCLK_CLK0);
        check("t1_grant_lat", grant_oh, 4'b0001);
        check("t1_busy", busy, 1);
        wait_drain("t1_drain");
        check("t1_pkt_count", pkt_count, 1);
        check("t1_busy_fall", busy, 0);

        // All sources requesting: rotation 0,1,2,3,0.
        apply_reset();
        load_pkt(0, 0, 2); load_pkt(0, 1, 2);
        load_pkt(1, 0, 2); load_pkt(2, 0, 2); load_pkt(3, 0, 2);
        expect_beats(0, 0, 0, 2); expect_beats(1, 0, 0, 2); expect_beats(2, 0, 0, 2);
        expect_beats(3, 0, 0, 2); expect_beats(0, 1, 0, 2);
        wait_drain("t2_drain");
        check("t2_pkt_count", pkt_count, 5);

        // Backpressure and source gaps on source 2.
        apply_reset();
        rdy_toggle = 1'b1;
        gap_en     = 1'b1;
        load_pkt(2, 7, 6);
        expect_beats(2, 7, 0, 6);
        wait_drain("t3_drain");
        check("t3_pkt_count", pkt_count, 1);
        rdy_toggle = 1'b0;
        gap_en     = 1'b0;

        // Enable drops mid-packet; pointer resumes at next source (1).
        base = out_beats;
        load_pkt(0, 3, 8);
        expect_beats(0, 3, 0, 8);
        wait_beats("t4_beat2", base + 2);
        enable = 1'b0;
        load_pkt(1, 4, 3); load_pkt(3, 5, 3);
        expect_beats(1, 4, 0, 3); expect_beats(3, 5, 0, 3);
        wait_beats("t4_first_done", base + 8);
        repeat (10) @(negedge FCLK_CLK0);
        check("t4_hold_grant", grant_oh, 0);
        check("t4_hold_busy", busy, 0);
        check("t4_hold_count", pkt_count, 2);
        check("t4_hold_pending", exp_q.size(), 6);
        enable = 1'b1;
        wait_drain("t4_drain");
        check("t4_pkt_count", pkt_count, 4);
`ifndef S2MM_ARB_PKT_LIMIT_EN
        check("overflow_off", overflow, 0);
`endif

        // Asynchronous reset mid-packet.
        base = out_beats;
        load_pkt(0, 6, 8);
        expect_beats(0, 6, 0, 8);
        wait_beats("t5_mid", base + 3);
        @(posedge FCLK_CLK0);
        #3;
        FCLK_RESET0_N = 1'b0;
        #1;
        check("t5_grant", grant_oh, 0);
        check("t5_busy", busy, 0);
        check("t5_count", pkt_count, 0);
        check("t5_tvalid", m_axis_tvalid, 0);
        check("t5_tlast", m_axis_tlast, 0);
        check("t5_tdata", m_axis_tdata, 0);
        check("t5_tready", s_axis_tready, 0);
        apply_reset();

`ifdef S2MM_ARB_PKT_LIMIT_EN
        // 130-beat packet split at MAX_BEATS.
        load_pkt(0, 9, 130);
        expect_beats(0, 9, 0, 128);
        expect_beats(0, 9, 128, 2);
        wait_drain("t6_drain");
        check("t6_overflow", overflow, 1);
        check("t6_pkt_count", pkt_count, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
